// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide responder.
// A radix-2 shift-add multiplier and a restoring divider share one
// 2*XLEN accumulator, one operand register and one iteration counter.
// Divide-by-zero and signed overflow resolve on the accept edge.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   alu_valid  request, held high until alu_ready is seen
//   alu_ready  one-cycle completion pulse (registered)
//   funct3     M-extension op select
//   rs1, rs2   operands, captured only at acceptance
//   rd         result, valid with alu_ready, held until next completion
//   busy       high while in CALC or DONE
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd;  // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] acc;   // mul: {product_hi, multiplier}; div: {rem, quot}

  // Request decode: operand signedness, magnitudes, result sign, special cases
  logic            a_signed, b_signed, sa, sb, is_div, neg_in;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b, special_rd;

  always_comb begin
    a_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa         = a_signed & rs1[XLEN-1];
    sb         = b_signed & rs2[XLEN-1];
    abs_a      = sa ? ((~rs1) + XLEN'(1)) : rs1;
    abs_b      = sb ? ((~rs2) + XLEN'(1)) : rs2;
    is_div     = funct3[2];
    // Remainder takes the dividend's sign; product and quotient take sA^sB
    neg_in     = (is_div && funct3[1]) ? sa : (sa ^ sb);
    div_zero   = is_div && (rs2 == '0);
    overflow   = is_div && !funct3[0] &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special    = div_zero || overflow;
    special_rd = '0;
    if (div_zero) begin
      special_rd = funct3[1] ? rs1 : '1;
    end else if (overflow) begin
      special_rd = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration of either algorithm, plus sign fix-up and result select
  logic [XLEN:0]     mul_sum, rem_sh, trial;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    // Shift {rem,quot} left by one, then trial-subtract the divisor
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    trial    = rem_sh - {1'b0, opnd};
    div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    acc_next = op[2] ? div_next : mul_next;
    prod_fix = neg ? ((~mul_next) + (2*XLEN)'(1)) : mul_next;
    quot_fix = neg ? ((~div_next[XLEN-1:0]) + XLEN'(1)) : div_next[XLEN-1:0];
    rem_fix  = neg ? ((~div_next[2*XLEN-1:XLEN]) + XLEN'(1))
                   : div_next[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quot_fix;
      default:                result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      op        <= '0;
      neg       <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      rd        <= '0;
      alu_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alu_ready <= 1'b0;
          if (alu_valid) begin
            op    <= funct3;
            neg   <= neg_in;
            count <= CW'(XLEN);
            busy  <= 1'b1;
            if (special) begin
              rd        <= special_rd;
              alu_ready <= 1'b1;
              state     <= DONE;
            end else begin
              opnd  <= is_div ? abs_b : abs_a;
              acc   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            rd        <= result;
            alu_ready <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          alu_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          alu_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results,
// latency, special cases, back-to-back requests and mid-op reset.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int doubles = 0;
  logic prev_ready = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ready pulses and any back-to-back ready cycles
  always @(negedge clk) begin
    if (alu_ready === 1'b1) pulses++;
    if (alu_ready === 1'b1 && prev_ready === 1'b1) doubles++;
    prev_ready = alu_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3    = f;
    rs1       = a;
    rs2       = b;
    alu_valid = 1'b1;
  endtask

  // Wait for ready; lat is the number of edges from acceptance. Inputs are
  // scrambled after acceptance; valid optionally drops mid-op.
  task automatic wait_ready(input int drop_at, output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      lat = i;
      if (i == 1) begin
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
      end
      if (i == drop_at) alu_valid = 1'b0;
      if (alu_ready === 1'b1) break;
    end
    check("ready_seen", {31'd0, alu_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                     input int drop_at);
    int lat;
    start(f, a, b);
    wait_ready(drop_at, lat);
    check({tag, "_rd"}, rd, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    check({tag, "_ready_low"}, {31'd0, alu_ready}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int p0;
    resetn    = 1'b0;
    alu_valid = 1'b0;
    funct3    = 3'd0;
    rs1       = 32'd0;
    rs2       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Multiplies
    run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run("mulh_neg", 3'b001, 32'hFFFFFFFD, 32'd5,      32'hFFFFFFFF, 33, 0);

    // Divides
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
    run("div_nd", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
    run("rem_nd", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 0);

    // Special cases resolve in one cycle
    run("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run("remu0",  3'b111, 32'h1234,     32'd0,        32'h1234,     1, 0);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Valid dropped mid-op still completes
    run("drop",   3'b111, 32'd100,      32'd7,        32'd2,        33, 5);

    // Back-to-back: valid reasserted the cycle after ready
    p0 = pulses;
    start(3'b000, 32'd3, 32'd4);
    wait_ready(0, lat);
    check("b2b_mul_rd", rd, 32'd12);
    check("b2b_mul_lat", 32'(lat), 32'd33);
    @(posedge clk);
    #1;
    check("b2b_gap_ready", {31'd0, alu_ready}, 32'd0);
    start(3'b101, 32'd9, 32'd3);
    @(posedge clk);
    #1;
    check("b2b_hold", rd, 32'd12);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_ready(0, lat);
    check("b2b_divu_rd", rd, 32'd3);
    check("b2b_divu_lat", 32'(lat + 1), 32'd33);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    check("b2b_pulses", 32'(pulses - p0), 32'd2);

    // Reset during CALC aborts with no ready pulse
    start(3'b101, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, alu_ready}, 32'd0);
    check("mid_rst_rd", rd, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    alu_valid = 1'b0;
    p0 = pulses;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", 32'(pulses - p0), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run("rst_divu", 3'b101, 32'd10, 32'd3, 32'd3, 33, 0);

    check("no_double_ready", 32'(doubles), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M arithmetic responder on the core's alu_valid/alu_ready handshake.
- The control FSM raises alu_valid for M-extension ops (op=OP, funct7b0=1). This block computes the result and pulses alu_ready when it is done.
- Uses a radix-2 shift-add multiplier and a restoring divider that share one iteration counter. Divide special cases resolve early.
- Sits beside the ALU in the datapath; its result is muxed onto the ALU result path.

Parameters:
- XLEN, 32, operand/result width; counter width is clog2(XLEN)+1.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- alu_valid  input  1  request from control FSM; held high until alu_ready is seen.
- alu_ready  output  1  one-cycle completion pulse.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (dividend / multiplicand).
- rs2  input  XLEN  operand B (divisor / multiplier).
- rd  output  XLEN  result; valid while alu_ready=1, held until the next acceptance.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, alu_ready=0, rd=0, busy=0, counter=0, internal accumulators=0. Reset asserted mid-CALC aborts the op immediately; no ready pulse follows.
- State machine:
  - IDLE: on the clk edge with alu_valid=1, accept the request.
    - Latch funct3.
    - Latch operand magnitudes: signed operand = abs value. Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; MUL treated as unsigned (low word is sign-independent).
    - Latch result sign: mul = sA^sB; quotient = sA^sB; remainder = sA.
    - Load counter=XLEN. Go to CALC, or directly to DONE for a special case.
  - CALC: one iteration per cycle; counter decrements; when counter reaches 1 the next state is DONE. Sign fix-up (two's-complement negate of the 2*XLEN product, quotient or remainder) and result select are registered into rd on the CALC->DONE edge.
    - Multiply: if multiplier LSB is set, add multiplicand into the upper half of the 2*XLEN accumulator; shift right 1.
    - Divide: shift {rem,quot} left 1; trial subtract divisor from rem; if no borrow, keep the difference and set quot LSB=1.
  - DONE: alu_ready=1 for exactly this cycle, rd valid; next state IDLE unconditionally. alu_valid still high in DONE is ignored.
  - IDLE after DONE: alu_valid=1 starts a new op. The initiator drops valid in the cycle after ready.
- Result select:
  - MUL: low XLEN of the product.
  - MULH/MULHSU/MULHU: high XLEN of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases, resolved in IDLE and written to rd on the accept edge, go straight to DONE:
  - Divide by zero: DIV/DIVU rd=all ones; REM/REMU rd=rs1.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF: DIV rd=0x80000000; REM rd=0.
  - Multiplies have no special case.
- Latency (from the first cycle alu_valid=1 in IDLE to the alu_ready cycle):
  - Normal ops: XLEN+1 cycles (33).
  - Special cases: 1 cycle.
- Operands are captured only at acceptance; changes on rs1/rs2/funct3 during CALC have no effect.
- A valid deasserted during CALC (protocol violation) does not abort; the op completes and the ready pulse is still issued.
- alu_ready is never high for two consecutive cycles.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB; alu_ready exactly 33 cycles after valid rise, single-cycle pulse.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, each with ready 1 cycle after valid. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0, also 1 cycle.
- Back-to-back: MUL 3x4, then DIVU 9/3 with valid reasserted the cycle after ready -> rd=12 then rd=3. Exactly two ready pulses; rd holds 12 until the second acceptance.
- Reset mid-op: assert resetn=0 at CALC cycle 10 -> alu_ready=0, rd=0, busy=0 immediately. After release, a fresh DIVU 10/3 completes with rd=3 in 33 cycles.
